// File: rtl/slave.sv
// Responder for the A/D channel link: executes one request at a time against a
// 16 x 32-bit register file and returns exactly one D-channel response.
module slave #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_opcode,
    input  logic [3:0]  a_mask,
    input  logic [3:0]  a_address,
    input  logic [31:0] a_data,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [3:0]  d_opcode,
    output logic [31:0] d_data,
    output logic        err_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_PUT_FULL = 4'h0;
    localparam logic [3:0] OP_PUT_PART = 4'h1;
    localparam logic [3:0] OP_GET      = 4'h4;
    localparam logic [3:0] ACK         = 4'h0;
    localparam logic [3:0] ACK_DATA    = 4'h1;
    localparam logic [3:0] CNT_LOAD    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  d_opcode_q, d_opcode_d;
    logic [31:0] d_data_q, d_data_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [16];
    logic [31:0] mem_d [16];

    // The request executes on its acceptance edge; WAIT/RESP only pace the reply.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        d_opcode_d = d_opcode_q;
        d_data_d   = d_data_q;
        err_d      = err_q;
        mem_d      = mem_q;
        case (state_q)
            IDLE: begin
                if (a_valid) begin
                    d_opcode_d = ACK;
                    d_data_d   = '0;
                    case (a_opcode)
                        OP_PUT_FULL: mem_d[a_address] = a_data;
                        OP_PUT_PART: begin
                            for (int b = 0; b < 4; b++) begin
                                if (a_mask[b]) begin
                                    mem_d[a_address][8*b +: 8] = a_data[8*b +: 8];
                                end
                            end
                        end
                        OP_GET: begin
                            d_opcode_d = ACK_DATA;
                            d_data_d   = mem_q[a_address];
                        end
                        default: err_d = 1'b1;
                    endcase
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (d_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            d_opcode_q <= '0;
            d_data_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_opcode_q <= d_opcode_d;
            d_data_q   <= d_data_d;
            err_q      <= err_d;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign a_ready  = (state_q == IDLE);
    assign d_valid  = (state_q == RESP);
    assign d_opcode = d_opcode_q;
    assign d_data   = d_data_q;
    assign err_flag = err_q;

endmodule

// File: tb/tb_slave.sv
// Bench for slave: three instances (LATENCY 1, 0, 15) driven by a directed table,
// hand-written corner sequences and randomized traffic against a word-level model.
module tb_slave;

    logic        clk = 1'b0;
    logic        rst_n    [3];
    logic        a_valid  [3];
    logic        a_ready  [3];
    logic [3:0]  a_opcode [3];
    logic [3:0]  a_mask   [3];
    logic [3:0]  a_address[3];
    logic [31:0] a_data   [3];
    logic        d_valid  [3];
    logic        d_ready  [3];
    logic [3:0]  d_opcode [3];
    logic [31:0] d_data   [3];
    logic        err_flag [3];

    int nvec = 0;
    int nmis = 0;

    logic [31:0] mdl  [3][16];
    logic        merr [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        slave #(.LATENCY((g == 0) ? 1 : (g == 1) ? 0 : 15)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .a_valid  (a_valid[g]),
            .a_ready  (a_ready[g]),
            .a_opcode (a_opcode[g]),
            .a_mask   (a_mask[g]),
            .a_address(a_address[g]),
            .a_data   (a_data[g]),
            .d_valid  (d_valid[g]),
            .d_ready  (d_ready[g]),
            .d_opcode (d_opcode[g]),
            .d_data   (d_data[g]),
            .err_flag (err_flag[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 15;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s dut%0d: got %h expected %h", name, i, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input int i);
        chk("rst_a_ready", i, 32'(a_ready[i]), 32'd1);
        chk("rst_d_valid", i, 32'(d_valid[i]), 32'd0);
        chk("rst_d_opcode", i, 32'(d_opcode[i]), 32'd0);
        chk("rst_d_data", i, d_data[i], 32'd0);
        chk("rst_err_flag", i, 32'(err_flag[i]), 32'd0);
    endtask

    task automatic model_clear(input int i);
        for (int k = 0; k < 16; k++) mdl[i][k] = '0;
        merr[i] = 1'b0;
    endtask

    // Word-level reference: what the response should carry and what memory becomes.
    task automatic model_exec(input int i, input logic [3:0] op, input logic [3:0] addr,
                              input logic [3:0] mask, input logic [31:0] data,
                              output logic [3:0] eop, output logic [31:0] edata);
        logic [31:0] m;
        eop = 4'h0;
        edata = '0;
        m = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        if (op == 4'h0) mdl[i][addr] = data;
        else if (op == 4'h1) mdl[i][addr] = (mdl[i][addr] & ~m) | (data & m);
        else if (op == 4'h4) begin
            eop = 4'h1;
            edata = mdl[i][addr];
        end else merr[i] = 1'b1;
    endtask

    // One full A/D transaction; bp cycles of back-pressure with an ignored A pulse during them.
    task automatic xact(input int i, input logic [3:0] op, input logic [3:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input int bp,
                        output logic [3:0] rop, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        chk("a_ready_idle", i, 32'(a_ready[i]), 32'd1);
        a_valid[i] = 1'b1; a_opcode[i] = op; a_address[i] = addr;
        a_mask[i] = mask; a_data[i] = data; d_ready[i] = (bp == 0);
        @(posedge clk);
        lat = 0;
        forever begin
            @(negedge clk);
            if (lat == 0) begin
                a_valid[i] = 1'b0;
                a_data[i] = ~data;
                chk("a_ready_busy", i, 32'(a_ready[i]), 32'd0);
            end
            lat++;
            if (d_valid[i]) break;
            if (lat > 40) begin
                chk("d_valid_timeout", i, 32'd0, 32'd1);
                break;
            end
        end
        rop = d_opcode[i];
        rdata = d_data[i];
        for (int b = 0; b < bp; b++) begin
            a_valid[i] = 1'b1; a_opcode[i] = 4'h0; a_address[i] = addr; a_data[i] = ~data;
            @(negedge clk);
            chk("bp_d_valid", i, 32'(d_valid[i]), 32'd1);
            chk("bp_d_opcode", i, 32'(d_opcode[i]), 32'(rop));
            chk("bp_d_data", i, d_data[i], rdata);
            chk("bp_a_ready", i, 32'(a_ready[i]), 32'd0);
        end
        a_valid[i] = 1'b0;
        d_ready[i] = 1'b1;
        @(negedge clk);
        chk("post_d_valid", i, 32'(d_valid[i]), 32'd0);
        chk("post_a_ready", i, 32'(a_ready[i]), 32'd1);
        d_ready[i] = 1'b0;
    endtask

    task automatic run(input int i, input logic [3:0] op, input logic [3:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input int bp);
        logic [3:0]  eop, rop;
        logic [31:0] edata, rdata;
        int lat;
        model_exec(i, op, addr, mask, data, eop, edata);
        xact(i, op, addr, mask, data, bp, rop, rdata, lat);
        chk("latency", i, 32'(lat), 32'(lat_of(i) + 1));
        chk("d_opcode", i, 32'(rop), 32'(eop));
        chk("d_data", i, rdata, edata);
        chk("err_flag", i, 32'(err_flag[i]), 32'(merr[i]));
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [3:0]  eop;
        logic [31:0] edata;
        logic        eerr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [3:0]  rop, op;
        logic [31:0] rdata, edata;
        logic [3:0]  eop;
        int lat;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; a_valid[i] = 1'b0; a_opcode[i] = '0; a_mask[i] = '0;
            a_address[i] = '0; a_data[i] = '0; d_ready[i] = 1'b0;
            model_clear(i);
        end
        #1;
        for (int i = 0; i < 3; i++) chk_reset_outputs(i);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        tbl[0]  = '{4'h0, 4'd3, 4'h0, 32'hDEADBEEF, 4'h0, 32'h0,        1'b0};
        tbl[1]  = '{4'h4, 4'd3, 4'h0, 32'h0,        4'h1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{4'h1, 4'd3, 4'h5, 32'h11223344, 4'h0, 32'h0,        1'b0};
        tbl[3]  = '{4'h4, 4'd3, 4'h2, 32'hFFFFFFFF, 4'h1, 32'hDE22BE44, 1'b0};
        tbl[4]  = '{4'h4, 4'd4, 4'hF, 32'h0,        4'h1, 32'h0,        1'b0};
        tbl[5]  = '{4'h1, 4'd4, 4'h0, 32'hCAFEF00D, 4'h0, 32'h0,        1'b0};
        tbl[6]  = '{4'h4, 4'd4, 4'h0, 32'h0,        4'h1, 32'h0,        1'b0};
        tbl[7]  = '{4'h0, 4'd5, 4'h0, 32'h12345678, 4'h0, 32'h0,        1'b0};
        tbl[8]  = '{4'h4, 4'd5, 4'h0, 32'h0,        4'h1, 32'h12345678, 1'b0};
        tbl[9]  = '{4'h7, 4'd3, 4'hF, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b1};
        tbl[10] = '{4'h4, 4'd3, 4'h0, 32'h0,        4'h1, 32'hDE22BE44, 1'b1};
        tbl[11] = '{4'h0, 4'd15, 4'h0, 32'hA5A50F0F, 4'h0, 32'h0,       1'b1};

        for (int v = 0; v < 12; v++) begin
            model_exec(0, tbl[v].op, tbl[v].addr, tbl[v].mask, tbl[v].data, eop, edata);
            xact(0, tbl[v].op, tbl[v].addr, tbl[v].mask, tbl[v].data, 0, rop, rdata, lat);
            chk("tbl_latency", 0, 32'(lat), 32'd2);
            chk("tbl_d_opcode", 0, 32'(rop), 32'(tbl[v].eop));
            chk("tbl_d_data", 0, rdata, tbl[v].edata);
            chk("tbl_err_flag", 0, 32'(err_flag[0]), 32'(tbl[v].eerr));
        end

        // Back-pressured Get of addr 15 with an ignored write pulse, then re-read.
        run(0, 4'h4, 4'd15, 4'h0, 32'h0, 5);
        run(0, 4'h4, 4'd15, 4'h0, 32'h0, 0);

        // Minimum and maximum latency builds.
        run(1, 4'h0, 4'd9, 4'h0, 32'h0BADF00D, 0);
        run(1, 4'h4, 4'd9, 4'h0, 32'h0, 0);
        run(2, 4'h0, 4'd9, 4'h0, 32'h600DCAFE, 0);
        run(2, 4'h4, 4'd9, 4'h0, 32'h0, 2);

        for (int n = 0; n < 120; n++) begin
            int i;
            int r;
            i = (n % 5 == 4) ? 2 : (n % 5 == 3) ? 1 : 0;
            r = $urandom_range(0, 9);
            if (r < 3) op = 4'h0;
            else if (r < 6) op = 4'h1;
            else if (r < 9) op = 4'h4;
            else begin
                op = 4'($urandom_range(0, 15));
                while (op == 4'h0 || op == 4'h1 || op == 4'h4) op = 4'($urandom_range(0, 15));
            end
            run(i, op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        // Reset in WAIT after a PutFullData: everything clears, the write is lost.
        @(negedge clk);
        a_valid[0] = 1'b1; a_opcode[0] = 4'h0; a_address[0] = 4'd6; a_data[0] = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        a_valid[0] = 1'b0;
        chk("wait_a_ready", 0, 32'(a_ready[0]), 32'd0);
        chk("wait_d_valid", 0, 32'(d_valid[0]), 32'd0);
        rst_n[0] = 1'b0;
        #1;
        chk_reset_outputs(0);
        model_clear(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        run(0, 4'h4, 4'd6, 4'h0, 32'h0, 0);
        run(0, 4'h4, 4'd3, 4'h0, 32'h0, 0);

        // Reset in RESP on the long-latency instance.
        @(negedge clk);
        a_valid[2] = 1'b1; a_opcode[2] = 4'h4; a_address[2] = 4'd9;
        @(posedge clk);
        @(negedge clk);
        a_valid[2] = 1'b0;
        repeat (16) @(negedge clk);
        chk("resp_d_valid", 2, 32'(d_valid[2]), 32'd1);
        rst_n[2] = 1'b0;
        #1;
        chk_reset_outputs(2);
        model_clear(2);
        @(negedge clk);
        rst_n[2] = 1'b1;
        run(2, 4'h4, 4'd9, 4'h0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
